// File: rtl/mult_result_accum.sv
// Accumulates blocks of BLOCK_LEN unsigned products into one registered sum per block.
// Optional macro SATURATE_EN clamps the accumulator on carry-out; by default it wraps.
module mult_result_accum #(
  parameter int IN_W      = 64,
  parameter int ACC_W     = 72,
  parameter int BLOCK_LEN = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IN_W-1:0]                in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           flush,
  output logic [ACC_W-1:0]               out_sum,
  output logic [$clog2(BLOCK_LEN+1)-1:0] out_count,
  output logic                           out_ovf,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int CNT_W = $clog2(BLOCK_LEN+1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN);

  typedef enum logic [1:0] {INIT, ACCUM, SEND} state_t;

  state_t            state, state_nx;
  logic [ACC_W-1:0]  acc, acc_nx, acc_add;
  logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
  logic              ovf, ovf_nx;
  logic              in_ready_nx, out_valid_nx, out_ovf_nx;
  logic [ACC_W-1:0]  out_sum_nx;
  logic [CNT_W-1:0]  out_count_nx;
  logic [ACC_W:0]    sum_ext;
  logic              carry, xfer;
  logic              close;
  logic [ACC_W-1:0]  close_sum;
  logic [CNT_W-1:0]  close_cnt;
  logic              close_ovf;

  // in_ready is only ever high in ACCUM, so it doubles as the state qualifier
  assign xfer    = in_valid & in_ready;
  assign sum_ext = {1'b0, acc} + {{(ACC_W+1-IN_W){1'b0}}, in_data};
  assign carry   = sum_ext[ACC_W];
  assign cnt_inc = cnt + 1'b1;

`ifdef SATURATE_EN
  // once clamped, stay clamped until the block closes
  assign acc_add = (ovf | carry) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_add = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    close     = 1'b0;
    close_sum = acc;
    close_cnt = cnt;
    close_ovf = ovf;
    if (state == ACCUM) begin
      if (xfer) begin
        close     = (cnt_inc == LAST) | flush;
        close_sum = acc_add;
        close_cnt = cnt_inc;
        close_ovf = ovf | carry;
      end else if (flush && cnt != '0) begin
        close = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    cnt_nx       = cnt;
    ovf_nx       = ovf;
    in_ready_nx  = in_ready;
    out_valid_nx = out_valid;
    out_sum_nx   = out_sum;
    out_count_nx = out_count;
    out_ovf_nx   = out_ovf;
    case (state)
      INIT: begin
        state_nx    = ACCUM;
        in_ready_nx = 1'b1;
      end
      ACCUM: begin
        if (close) begin
          out_sum_nx   = close_sum;
          out_count_nx = close_cnt;
          out_ovf_nx   = close_ovf;
          out_valid_nx = 1'b1;
          in_ready_nx  = 1'b0;
          acc_nx       = '0;
          cnt_nx       = '0;
          ovf_nx       = 1'b0;
          state_nx     = SEND;
        end else if (xfer) begin
          acc_nx = acc_add;
          cnt_nx = cnt_inc;
          ovf_nx = ovf | carry;
        end
      end
      SEND: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          in_ready_nx  = 1'b1;
          state_nx     = ACCUM;
        end
      end
      default: begin
        state_nx    = INIT;
        in_ready_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      ovf       <= ovf_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      out_sum   <= out_sum_nx;
      out_count <= out_count_nx;
      out_ovf   <= out_ovf_nx;
    end
  end

endmodule

// File: tb/tb_mult_result_accum.sv
// Directed bench: default instance for block/flush/backpressure/reset, narrow instance for overflow.
module tb_mult_result_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid, flush, out_ready;
  logic        in_ready, out_ovf, out_valid;
  logic [71:0] out_sum;
  logic [3:0]  out_count;

  logic [63:0] in_data2;
  logic        in_valid2, flush2, out_ready2;
  logic        in_ready2, out_ovf2, out_valid2;
  logic [63:0] out_sum2;
  logic [1:0]  out_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_result_accum dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mult_result_accum #(.IN_W(64), .ACC_W(64), .BLOCK_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .flush(flush2), .out_sum(out_sum2), .out_count(out_count2), .out_ovf(out_ovf2),
    .out_valid(out_valid2), .out_ready(out_ready2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] v, input logic fl);
    in_valid = 1'b1;
    in_data  = v;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_checks++; if (out_sum !== 72'd0) begin n_fail++; $display("FAIL rst_out_sum got %0d want 0", out_sum); end
    n_checks++; if (out_count !== 4'd0) begin n_fail++; $display("FAIL rst_out_count got %0d want 0", out_count); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_out_ovf got %0b want 0", out_ovf); end
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL init_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic;
    int pulses;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %0b want 0 at %0d", out_valid, i); end
      send(64'(i), 1'b0);
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    n_checks++; if (out_sum !== 72'd36) begin n_fail++; $display("FAIL basic_sum got %0d want 36", out_sum); end
    n_checks++; if (out_count !== 4'd8) begin n_fail++; $display("FAIL basic_count got %0d want 8", out_count); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %0b want 0", out_ovf); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready got %0b want 0", in_ready); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL basic_pulse_len got %0d extra want 0", pulses); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_rearm got %0b want 1", in_ready); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(64'd100, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %0b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 64'd55;
      tick();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %0b want 0 cyc %0d", in_ready, i); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got %0b want 1 cyc %0d", out_valid, i); end
      n_checks++; if (out_sum !== 72'd800) begin n_fail++; $display("FAIL bp_hold_sum got %0d want 800 cyc %0d", out_sum, i); end
      n_checks++; if (out_count !== 4'd8) begin n_fail++; $display("FAIL bp_hold_count got %0d want 8 cyc %0d", out_count, i); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    send(64'd5, 1'b0);
    send(64'd7, 1'b0);
    send(64'd9, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pre_valid got %0b want 0", out_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %0b want 1", out_valid); end
    n_checks++; if (out_sum !== 72'd21) begin n_fail++; $display("FAIL flush_sum got %0d want 21", out_sum); end
    n_checks++; if (out_count !== 4'd3) begin n_fail++; $display("FAIL flush_count got %0d want 3", out_count); end
    tick();
    send(64'd5, 1'b0);
    send(64'd7, 1'b0);
    send(64'd9, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flushx_valid got %0b want 1", out_valid); end
    n_checks++; if (out_sum !== 72'd21) begin n_fail++; $display("FAIL flushx_sum got %0d want 21", out_sum); end
    n_checks++; if (out_count !== 4'd3) begin n_fail++; $display("FAIL flushx_count got %0d want 3", out_count); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flushx_clear got %0b want 0", out_valid); end
  endtask

  task automatic test_flush_ignored;
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush0_valid got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush0_ready got %0b want 1", in_ready); end
    out_ready = 1'b0;
    send(64'd3, 1'b0);
    send(64'd4, 1'b1);
    n_checks++; if (out_count !== 4'd2 || out_sum !== 72'd7) begin n_fail++; $display("FAIL flushs_result got %0d/%0d want 7/2", out_sum, out_count); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL flushs_state got v%0b r%0b want v1 r0", out_valid, in_ready); end
    n_checks++; if (out_sum !== 72'd7 || out_count !== 4'd2) begin n_fail++; $display("FAIL flushs_hold got %0d/%0d want 7/2", out_sum, out_count); end
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flushs_after got v%0b r%0b want v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(64'd1000, 1'b0);
    rst = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_rst got v%0b r%0b want v0 r0", out_valid, in_ready); end
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_init got v%0b r%0b want v0 r1", out_valid, in_ready); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_early_valid got %0b want 0 at %0d", out_valid, i); end
      send(64'd1, 1'b0);
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_valid got %0b want 1", out_valid); end
    n_checks++; if (out_sum !== 72'd8) begin n_fail++; $display("FAIL rmid_sum got %0d want 8", out_sum); end
    n_checks++; if (out_count !== 4'd8) begin n_fail++; $display("FAIL rmid_count got %0d want 8", out_count); end
    tick();
  endtask

  task automatic test_overflow;
    logic [63:0] exp_sum;
`ifdef SATURATE_EN
    exp_sum = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    exp_sum = 64'd1;
`endif
    out_ready2 = 1'b1;
    n_checks++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL ovf_ready got %0b want 1", in_ready2); end
    in_valid2 = 1'b1;
    in_data2  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    in_data2  = 64'd2;
    tick();
    in_valid2 = 1'b0;
    n_checks++; if (out_valid2 !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got %0b want 1", out_valid2); end
    n_checks++; if (out_sum2 !== exp_sum) begin n_fail++; $display("FAIL ovf_sum got %0h want %0h", out_sum2, exp_sum); end
    n_checks++; if (out_ovf2 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", out_ovf2); end
    n_checks++; if (out_count2 !== 2'd2) begin n_fail++; $display("FAIL ovf_count got %0d want 2", out_count2); end
    tick();
    n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0b want 0", out_valid2); end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data2 = '0; in_valid2 = 1'b0; flush2 = 1'b0; out_ready2 = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_flush_ignored();
    test_reset_mid();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_result_accum.md
MULT_RESULT_ACCUM -- requirements
Module: mult_result_accum

Interface
REQ-001 Parameter IN_W, default 64, width of each incoming multiplier product.
REQ-002 Parameter ACC_W, default 72, accumulator and out_sum width; SHALL be >= IN_W.
REQ-003 Parameter BLOCK_LEN, default 8, products per accumulation block; SHALL be >= 1.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port in_data  input  IN_W  unsigned product from the upstream multiplier stage.
REQ-007 Port in_valid  input  1  in_data is valid.
REQ-008 Port in_ready  output  1  registered; block accepts in_data.
REQ-009 Port flush  input  1  requests early close of a partial block.
REQ-010 Port out_sum  output  ACC_W  registered block sum.
REQ-011 Port out_count  output  $clog2(BLOCK_LEN+1)  number of products in out_sum.
REQ-012 Port out_ovf  output  1  an accumulation carry-out occurred in this block.
REQ-013 Port out_valid  output  1  out_sum, out_count and out_ovf are valid.
REQ-014 Port out_ready  input  1  downstream accepts the result.

Function
REQ-015 The FSM SHALL have three states, INIT, ACCUM and SEND; INIT SHALL go to ACCUM unconditionally after one cycle and SHALL set in_ready to 1.
REQ-016 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; in_ready SHALL be 1 only in ACCUM.
REQ-017 Each transfer in ACCUM SHALL add zero-extended in_data to acc and increment cnt.
REQ-018 A transfer that makes cnt equal BLOCK_LEN SHALL, on the same edge, load out_sum with the final sum, out_count with BLOCK_LEN and out_ovf with the block overflow flag; it SHALL set out_valid=1 and in_ready=0, clear acc, cnt and the overflow flag, and go to SEND.
REQ-019 out_valid SHALL rise on the edge of the last transfer, giving a latency of 1 cycle from that transfer's edge to the result being visible.
REQ-020 flush=1 in ACCUM with cnt>0 and no transfer SHALL close the block as in REQ-018, with out_count=cnt.
REQ-021 flush and a transfer on the same edge SHALL include the transferred product, then close the block.
REQ-022 flush with cnt=0 and no transfer SHALL be ignored; flush in INIT or SEND SHALL be ignored.
REQ-023 In SEND, out_sum, out_count and out_ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 out_ready=1 in SEND SHALL clear out_valid, set in_ready=1 and go to ACCUM; there is no bubble beyond that one edge.
REQ-025 in_data SHALL be ignored whenever in_ready=0.

Reset
REQ-026 rst=1 SHALL force state=INIT, in_ready=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, acc=0, cnt=0 and the overflow flag=0.
REQ-027 rst asserted mid-block or in SEND SHALL discard the partial sum or the pending result with no output.
REQ-028 rst SHALL take priority over every other input.

Configuration
REQ-029 Macro SATURATE_EN: when defined, a carry-out of acc SHALL clamp acc to 2^ACC_W-1, keep it clamped for the rest of the block, and set the overflow flag.
REQ-030 When SATURATE_EN is undefined, acc SHALL wrap modulo 2^ACC_W and the overflow flag SHALL still be set on the carry-out.

Verification
REQ-031 Defaults; products 1..8 sent back-to-back with out_ready=1 -> one result: out_sum=36, out_count=8, out_ovf=0, out_valid high for 1 cycle.
REQ-032 Products 5, 7, 9, then flush with no valid -> out_sum=21, out_count=3; flush pulsed on the 3rd transfer edge -> same result.
REQ-033 Full block of 8x100 with out_ready=0 for 5 cycles -> out_sum=800 held, in_ready=0 for those 5 cycles, in_valid ignored; out_ready=1 -> in_ready=1 on the next edge.
REQ-034 ACC_W=IN_W=64, BLOCK_LEN=2, inputs 2^64-1 then 2 -> without SATURATE_EN out_sum=1 and out_ovf=1; with SATURATE_EN out_sum=2^64-1 and out_ovf=1.
REQ-035 rst pulsed after 4 of 8 transfers, then 8x1 sent -> out_sum=8 and out_count=8; no result is emitted for the discarded 4.
REQ-036 flush with cnt=0, and flush during SEND -> no extra out_valid pulse and no state change.
